alu_issue_ctrl: RTL and testbench

Byte-serial command/operand sequencer and result capture stage wrapped around the combinational 8-bit ALU. It accepts a command byte and operand bytes over a valid/ready stream and drives registered operands and control onto the ALU ports. After a configurable settle time it captures RESULT and the four flags, then presents them on an output valid/ready stream. A chain mode reuses the last captured result as operand A, so multi-step arithmetic needs no host round trip for A.

---
 rtl/alu_issue_ctrl_pkg.sv | 48 ++++
 rtl/alu_issue_ctrl_if.sv | 44 ++++
 rtl/alu_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the byte-serial ALU issue controller: data widths,
// command-byte layout, ALU control encodings and FSM states.
package alu_issue_ctrl_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned SAMT_W  = 4;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned CNT_W   = 2;

  localparam int unsigned CMD_CTRL_LSB  = 0;
  localparam int unsigned CMD_SAMT_LSB  = 3;
  localparam int unsigned CMD_CHAIN_BIT = 7;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD     = 3'b000,
    ALU_SUB     = 3'b001,
    ALU_AND     = 3'b010,
    ALU_OR      = 3'b011,
    ALU_SHL_ADD = 3'b100,
    ALU_SHL_SUB = 3'b101,
    ALU_SHR_ADD = 3'b110,
    ALU_SHR_SUB = 3'b111
  } alu_op_e;

  // Field order mirrors the command byte: [7] chain, [6:3] s_amt, [2:0] control.
  typedef struct packed {
    logic              chain;
    logic [SAMT_W-1:0] s_amt;
    logic [CTRL_W-1:0] control;
  } cmd_t;

  typedef struct packed {
    logic overflow;
    logic negative;
    logic zero;
    logic carry;
  } flags_t;

  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_OUT  = 3'd4
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Byte input stream, ALU operand/result ports and result output stream
// of the ALU issue controller.
interface alu_issue_ctrl_if;
  import alu_issue_ctrl_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;

  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [CTRL_W-1:0]  alu_control;
  logic [SAMT_W-1:0]  alu_s_amt;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_zero;
  logic               alu_negative;
  logic               alu_carry;
  logic               alu_overflow;

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_result;
  logic [FLAGS_W-1:0] out_flags;
  logic               busy;

  modport slave (
    input  in_valid, in_data,
    input  alu_result, alu_zero, alu_negative, alu_carry, alu_overflow,
    input  out_ready,
    output in_ready,
    output alu_a, alu_b, alu_control, alu_s_amt,
    output out_valid, out_result, out_flags, busy
  );

  modport master (
    output in_valid, in_data,
    output alu_result, alu_zero, alu_negative, alu_carry, alu_overflow,
    output out_ready,
    input  in_ready,
    input  alu_a, alu_b, alu_control, alu_s_amt,
    input  out_valid, out_result, out_flags, busy
  );

endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequences command/operand bytes onto registered ALU inputs, waits ISSUE_WAIT
// cycles, then captures result and flags into an output valid/ready stage.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned ISSUE_WAIT = 1
) (
  input logic            clk,
  input logic            rst,
  alu_issue_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ISSUE_WAIT - 32'd1);

  state_e             state_q,      state_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [DATA_W-1:0]  alu_a_q,      alu_a_d;
  logic [DATA_W-1:0]  alu_b_q,      alu_b_d;
  logic [CTRL_W-1:0]  ctrl_q,       ctrl_d;
  logic [SAMT_W-1:0]  s_amt_q,      s_amt_d;
  logic [DATA_W-1:0]  acc_q,        acc_d;
  logic               acc_valid_q,  acc_valid_d;
  logic [DATA_W-1:0]  out_result_q, out_result_d;
  flags_t             out_flags_q,  out_flags_d;
  logic               out_valid_q,  out_valid_d;
  logic               in_ready_q,   in_ready_d;
  logic               busy_q,       busy_d;

  cmd_t cmd;
  logic in_fire;
  logic out_fire;

  assign cmd      = cmd_t'(bus.in_data);
  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;

  // Next-state and datapath updates; handshake flags are decoded from the next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    ctrl_d       = ctrl_q;
    s_amt_d      = s_amt_q;
    acc_d        = acc_q;
    acc_valid_d  = acc_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;

    unique case (state_q)
      S_CMD: begin
        if (in_fire) begin
          ctrl_d  = cmd.control;
          s_amt_d = cmd.s_amt;
          if (cmd.chain) begin
            alu_a_d = acc_valid_q ? acc_q : '0;
            state_d = S_B;
          end else begin
            state_d = S_A;
          end
        end
      end
      S_A: begin
        if (in_fire) begin
          alu_a_d = bus.in_data;
          state_d = S_B;
        end
      end
      S_B: begin
        if (in_fire) begin
          alu_b_d = bus.in_data;
          cnt_d   = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == WAIT_LAST) begin
          out_result_d = bus.alu_result;
          out_flags_d  = {bus.alu_overflow, bus.alu_negative,
                          bus.alu_zero, bus.alu_carry};
          acc_d        = bus.alu_result;
          acc_valid_d  = 1'b1;
          state_d      = S_OUT;
        end
      end
      S_OUT: begin
        if (out_fire) begin
          state_d = S_CMD;
        end
      end
      default: begin
        state_d = S_CMD;
      end
    endcase

    in_ready_d  = (state_d == S_CMD) || (state_d == S_A) || (state_d == S_B);
    busy_d      = (state_d != S_CMD);
    out_valid_d = (state_d == S_OUT);
  end

  // State register; in_ready comes out of reset high because the FSM idles in S_CMD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CMD;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      ctrl_q       <= '0;
      s_amt_q      <= '0;
      acc_q        <= '0;
      acc_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      ctrl_q       <= ctrl_d;
      s_amt_q      <= s_amt_d;
      acc_q        <= acc_d;
      acc_valid_q  <= acc_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_control = ctrl_q;
  assign bus.alu_s_amt   = s_amt_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_flags   = out_flags_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: an ALU stand-in, a transaction-level
// expectation queue checked every output cycle, and hand-computed literals.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.ISSUE_WAIT(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Returns {overflow, negative, zero, carry, result}; shifts act on the add/sub result.
  function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] ctl, input logic [3:0] s);
    logic [7:0] bb;
    logic [7:0] r;
    logic [8:0] sum;
    logic       c;
    logic       v;
    bb  = ctl[0] ? ~b : b;
    sum = 9'(a) + 9'(bb) + 9'(ctl[0]);
    c   = sum[8];
    r   = sum[7:0];
    v   = (a[7] == bb[7]) && (r[7] != a[7]);
    if (ctl == 3'b010) begin
      r = a & b; c = 1'b0; v = 1'b0;
    end else if (ctl == 3'b011) begin
      r = a | b; c = 1'b0; v = 1'b0;
    end else if (ctl[2]) begin
      r = ctl[1] ? (r >> s) : (r << s);
    end
    return {v, r[7], (r == 8'h00), c, r};
  endfunction

  logic [11:0] alu_out;
  always_comb alu_out = alu_fn(bus.alu_a, bus.alu_b, bus.alu_control, bus.alu_s_amt);
  assign bus.alu_result   = alu_out[7:0];
  assign bus.alu_carry    = alu_out[8];
  assign bus.alu_zero     = alu_out[9];
  assign bus.alu_negative = alu_out[10];
  assign bus.alu_overflow = alu_out[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] ctl;
    logic [3:0] s;
    logic [7:0] res;
    logic [3:0] flags;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cmp_e;
  logic [7:0] m_acc    = 8'h00;
  int         n_pushed = 0;
  int         n_popped = 0;

  // Every cycle a result is offered it must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        cmp_e = exp_q[0];
        chk("out_result",  32'(bus.out_result),  32'(cmp_e.res));
        chk("out_flags",   32'(bus.out_flags),   32'(cmp_e.flags));
        chk("alu_a_hold",  32'(bus.alu_a),       32'(cmp_e.a));
        chk("alu_b_hold",  32'(bus.alu_b),       32'(cmp_e.b));
        chk("alu_ctl",     32'(bus.alu_control), 32'(cmp_e.ctl));
        chk("alu_s_amt",   32'(bus.alu_s_amt),   32'(cmp_e.s));
        chk("no_overlap",  32'(bus.in_ready),    32'd0);
        chk("busy_out",    32'(bus.busy),        32'd1);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
      m_acc = exp_q[0].res;
      void'(exp_q.pop_front());
      n_popped++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) break;
      @(negedge clk);
    end
    chk("send_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] lit_res, input logic [3:0] lit_flags,
                       input int hold);
    exp_t       e;
    logic [7:0] res_seen;
    logic [3:0] flg_seen;
    logic [7:0] a_seen;
    e.a   = cmd[7] ? m_acc : a;
    e.b   = b;
    e.ctl = cmd[2:0];
    e.s   = cmd[6:3];
    {e.flags, e.res} = alu_fn(e.a, e.b, e.ctl, e.s);
    exp_q.push_back(e);
    n_pushed++;
    bus.out_ready = (hold == 0);

    send_byte(cmd);
    if (cmd[7]) begin
      chk("chain_a", 32'(bus.alu_a), 32'(e.a));
      chk("chain_wait_b", 32'(bus.in_ready), 32'd1);
    end else begin
      send_byte(a);
    end
    send_byte(b);

    for (int n = 1; n <= int'(IW) + 1; n++) begin
      @(negedge clk);
      if (n <= int'(IW)) chk("early_valid", 32'(bus.out_valid), 32'd0);
      else               chk("latency_valid", 32'(bus.out_valid), 32'd1);
    end
    chk("lit_result", 32'(bus.out_result), 32'(lit_res));
    chk("lit_flags",  32'(bus.out_flags),  32'(lit_flags));

    res_seen = bus.out_result;
    flg_seen = bus.out_flags;
    a_seen   = bus.alu_a;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      @(negedge clk);
      chk("hold_valid",  32'(bus.out_valid),  32'd1);
      chk("hold_ready",  32'(bus.in_ready),   32'd0);
      chk("hold_result", 32'(bus.out_result), 32'(res_seen));
      chk("hold_flags",  32'(bus.out_flags),  32'(flg_seen));
      chk("hold_alu_a",  32'(bus.alu_a),      32'(a_seen));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", 32'(bus.out_valid), 32'd0);
    chk("post_ready", 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),   32'd1);
    chk("rst_out_valid", 32'(bus.out_valid),  32'd0);
    chk("rst_busy",      32'(bus.busy),       32'd0);
    chk("rst_alu_a",     32'(bus.alu_a),      32'd0);
    chk("rst_out_res",   32'(bus.out_result), 32'd0);
    rst = 1'b0;

    do_op(8'h00, 8'h03, 8'h02, 8'h05, 4'b0000, 0);
    do_op(8'h01, 8'h02, 8'h03, 8'hFF, 4'b0100, 0);
    do_op(8'h01, 8'h07, 8'h07, 8'h00, 4'b0011, 0);
    do_op(8'h00, 8'h7F, 8'h01, 8'h80, 4'b1100, 0);
    do_op(8'h00, 8'hFF, 8'h02, 8'h01, 4'b0001, 0);
    do_op(8'h00, 8'h03, 8'h02, 8'h05, 4'b0000, 0);
    do_op(8'h80, 8'h00, 8'h01, 8'h06, 4'b0000, 0);
    do_op(8'h14, 8'h01, 8'h02, 8'h0C, 4'b0000, 0);
    do_op(8'h03, 8'hF0, 8'h0F, 8'hFF, 4'b0100, 5);

    // Abandon a command after its A byte, then chain from the cleared accumulator.
    send_byte(8'h00);
    send_byte(8'h44);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid_rst_busy",      32'(bus.busy),      32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_alu_a",     32'(bus.alu_a),     32'd0);
    exp_q.delete();
    m_acc = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h80, 8'h00, 8'h09, 8'h09, 4'b0000, 0);

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("ops_done",    32'(n_popped),     32'(n_pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
